// File: rtl/count_enable_gen.sv
// count_enable_gen: prescaled enable-tick generator (free-run, burst, step) for the up/down counters.
// Define COUNT_ENABLE_GEN_SYNC_EN to pass start/stop/step through 2-flop synchronizers.
module count_enable_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  output logic               enable,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  logic [1:0]         state;
  logic [DIV_W-1:0]   pre, div_r;
  logic [BURST_W-1:0] rem;
  logic               start_d, step_d, start_i, stop_i, step_i;
`ifdef COUNT_ENABLE_GEN_SYNC_EN
  logic [1:0] start_s, stop_s, step_s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      start_s <= '0;
      stop_s  <= '0;
      step_s  <= '0;
    end else begin
      start_s <= {start_s[0], start};
      stop_s  <= {stop_s[0], stop};
      step_s  <= {step_s[0], step};
    end
  assign start_i = start_s[1];
  assign stop_i  = stop_s[1];
  assign step_i  = step_s[1];
`else
  assign start_i = start;
  assign stop_i  = stop;
  assign step_i  = step;
`endif
  logic start_edge, step_edge, tick;
  assign start_edge = start_i & ~start_d;
  assign step_edge  = step_i & ~step_d;
  assign tick       = pre == div_r;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      pre     <= '0;
      div_r   <= '0;
      rem     <= '0;
      start_d <= 1'b0;
      step_d  <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_d <= start_i;
      step_d  <= step_i;
      enable  <= 1'b0;
      done    <= 1'b0;
      if (state == IDLE) begin
        busy <= 1'b0;
        if (start_edge && (mode == 2'b01 || (mode == 2'b10 && burst_len != '0))) begin
          state <= (mode == 2'b01) ? RUN : BURST;
          busy  <= 1'b1;
          pre   <= '0;
          div_r <= div;
          rem   <= burst_len;
        end else begin
          done   <= start_edge && mode == 2'b10;
          enable <= step_edge && mode == 2'b11;
        end
      end else if (stop_i) begin
        // abort suppresses any tick that would land on this edge
        state <= IDLE;
        busy  <= 1'b0;
        pre   <= '0;
        rem   <= '0;
      end else if (tick) begin
        enable <= 1'b1;
        pre    <= '0;
        if (state == BURST) begin
          rem <= rem - 1'b1;
          if (rem == 1) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed stimulus with an arithmetic cadence model checked every cycle.
module tb_count_enable_gen;
  logic clk = 0, rst = 0, start = 0, stop = 0, step = 0;
  logic [7:0] div = 0;
  logic [1:0] mode = 0;
  logic [3:0] burst_len = 0;
  logic enable, busy, done;
  int checks = 0, errors = 0;
  int cyc = 0, act = 0, t0 = 0, dv = 0, len = 0;
  int e_en = 0, e_busy = 0, e_done = 0, ps = 0, pst = 0, se, te;
  int en_cnt, en_first, en_last, done_cnt, done_last, tl;

  count_enable_gen dut (.clk(clk), .rst(rst), .div(div), .mode(mode), .burst_len(burst_len),
    .start(start), .stop(stop), .step(step), .enable(enable), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act_v, exp_v);
    end
  endtask

  // Model: ticks fall where (cycle - launch) is a positive multiple of div+1
  always @(posedge clk) begin
    cyc++;
    e_en = 0;
    e_done = 0;
    if (!rst) begin
      act = 0; e_busy = 0; ps = 0; pst = 0;
    end else begin
      se = start && !ps;
      te = step && !pst;
      ps = start;
      pst = step;
      if (act == 0) begin
        e_busy = 0;
        if (se && mode == 1) begin act = 1; t0 = cyc; dv = div; e_busy = 1; end
        else if (se && mode == 2 && burst_len == 0) e_done = 1;
        else if (se && mode == 2) begin act = 2; t0 = cyc; dv = div; len = burst_len; e_busy = 1; end
        else if (mode == 3 && te) e_en = 1;
      end else if (stop) begin
        act = 0; e_busy = 0;
      end else if ((cyc - t0) % (dv + 1) == 0) begin
        e_en = 1;
        if (act == 2 && (cyc - t0) / (dv + 1) == len) begin e_done = 1; act = 0; end
      end
    end
  end

  always @(negedge clk) begin
    check("enable", enable, e_en);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    if (enable) begin
      en_cnt++;
      en_last = cyc;
      if (en_cnt == 1) en_first = cyc;
    end
    if (done) begin done_cnt++; done_last = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    en_cnt = 0; en_first = -1; en_last = -1; done_cnt = 0; done_last = -1;
  endtask

  task automatic launch();
    start = 1;
    tl = cyc + 1;
    tick(1);
    start = 0;
  endtask

  initial begin
    clr();
    tick(1);
    start = 1; step = 1;
    tick(1);
    start = 0; step = 0;
    check("rst_outs", {enable, busy, done}, 0);
    rst = 1;
    tick(1);
    check("post_rst_outs", {enable, busy, done}, 0);
    // free-run div=3
    div = 3; mode = 1; clr();
    launch();
    tick(16);
    check("run_cnt", en_cnt, 4);
    check("run_first", en_first, tl + 4);
    check("run_last", en_last, tl + 16);
    stop = 1; mode = 3;
    tick(1);
    stop = 0; clr();
    tick(10);
    check("run_stop_cnt", en_cnt, 0);
    check("run_stop_busy", busy, 0);
    // burst div=1 len=5, latched values must survive input changes
    div = 1; burst_len = 5; mode = 2; clr();
    launch();
    div = 7; burst_len = 2; mode = 1;
    tick(12);
    check("burst_cnt", en_cnt, 5);
    check("burst_first", en_first, tl + 2);
    check("burst_last", en_last, tl + 10);
    check("burst_done_cnt", done_cnt, 1);
    check("burst_done_at", done_last, tl + 10);
    check("burst_busy_end", busy, 0);
    // burst_len=0
    mode = 2; burst_len = 0; clr();
    launch();
    tick(4);
    check("len0_en", en_cnt, 0);
    check("len0_done", done_cnt, 1);
    check("len0_done_at", done_last, tl);
    // burst_len=15, div=0
    div = 0; burst_len = 15; clr();
    launch();
    tick(20);
    check("len15_cnt", en_cnt, 15);
    check("len15_first", en_first, tl + 1);
    check("len15_last", en_last, tl + 15);
    // step held high
    mode = 3; clr();
    step = 1; tl = cyc + 1;
    tick(10);
    check("step_cnt", en_cnt, 1);
    check("step_at", en_first, tl);
    step = 0;
    tick(2);
    step = 1;
    tick(3);
    step = 0;
    check("step_cnt2", en_cnt, 2);
    // stop and start together in IDLE: start wins
    mode = 1; div = 0; clr();
    stop = 1;
    launch();
    stop = 0;
    tick(3);
    check("start_wins_cnt", en_cnt, 3);
    stop = 1;
    tick(1);
    stop = 0;
    // stop on the edge of the first burst tick
    mode = 2; div = 1; burst_len = 5; clr();
    launch();
    tick(1);
    stop = 1;
    tick(1);
    stop = 0;
    tick(5);
    check("abort_en", en_cnt, 0);
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy, 0);
    // reset mid-burst, then a full restart
    clr();
    launch();
    tick(4);
    rst = 0;
    #1;
    check("midrst_outs", {enable, busy, done}, 0);
    tick(1);
    rst = 1; clr();
    launch();
    tick(12);
    check("restart_cnt", en_cnt, 5);
    check("restart_done", done_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
